// File: rtl/gold_pkg.sv
// Shared definitions for the gold ring-router network interface.
// Holds the register map, packet field positions and the packet/register width.
package gold_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned STAT_W = 16;

   // Register map
   localparam logic [ADDR_W-1:0] ADDR_IN_BUF   = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_IN_STAT  = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_OUT_BUF  = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_OUT_STAT = 2'd3;

   // Packet field positions
   localparam int unsigned VC_BIT  = 63;
   localparam int unsigned DIR_BIT = 30;
   localparam int unsigned HOP_MSB = 25;
   localparam int unsigned HOP_LSB = 18;

endpackage

// File: rtl/gold_nic_chbuf.sv
// Single-entry channel buffer: data register plus full flag.
// Ports: clk, reset (async, active-low), load (capture d, set full),
//        clear (drop full flag), d (write data), q (held data), full.
// The data register keeps its value on clear; only reset zeroes it.
module gold_nic_chbuf
   import gold_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              full
);

   // Load takes priority; the parent never asserts both together
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/gold_nic.sv
// Processor-side network interface for the bidirectional ring router.
// Ports: clk, reset (async, active-low); processor side addr/d_in/d_out/
//        nic_en/nic_wr_en; router PE input channel net_so/net_ro/net_do,
//        gated by net_polarity; router PE output channel net_si/net_ri/net_di.
// Optional feature macro GOLD_NIC_STATS_EN adds saturating tx/rx counters
// visible in bits [31:16] of the status registers.
module gold_nic
   import gold_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              nic_en,
   input  logic              nic_wr_en,
   output logic              net_so,
   input  logic              net_ro,
   output logic [DATA_W-1:0] net_do,
   input  logic              net_polarity,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di
);

   logic [DATA_W-1:0] out_q;
   logic [DATA_W-1:0] in_q;
   logic              out_full;
   logic              in_full;
   logic              out_load;
   logic              in_load;
   logic              in_clear;
   logic              rd;
   logic              wr;
   logic [STAT_W-1:0] tx_cnt;
   logic [STAT_W-1:0] rx_cnt;

   assign rd = nic_en & ~nic_wr_en;
   assign wr = nic_en &  nic_wr_en;

   // Channel handshakes; a write while full (including during injection) is dropped
   assign out_load = wr & (addr == ADDR_OUT_BUF) & ~out_full;
   assign net_so   = out_full & net_ro & (out_q[VC_BIT] == net_polarity);
   assign net_do   = out_full ? out_q : '0;
   assign net_ri   = ~in_full;
   assign in_load  = net_si & ~in_full;
   assign in_clear = rd & (addr == ADDR_IN_BUF) & in_full;

   gold_nic_chbuf u_out_buf (
      .clk   (clk),
      .reset (reset),
      .load  (out_load),
      .clear (net_so),
      .d     (d_in),
      .q     (out_q),
      .full  (out_full)
   );

   gold_nic_chbuf u_in_buf (
      .clk   (clk),
      .reset (reset),
      .load  (in_load),
      .clear (in_clear),
      .d     (net_di),
      .q     (in_q),
      .full  (in_full)
   );

`ifdef GOLD_NIC_STATS_EN
   // Saturating traffic counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_cnt <= '0;
         rx_cnt <= '0;
      end else begin
         if (net_so && (tx_cnt != {STAT_W{1'b1}})) tx_cnt <= tx_cnt + STAT_W'(1);
         if (in_load && (rx_cnt != {STAT_W{1'b1}})) rx_cnt <= rx_cnt + STAT_W'(1);
      end
   end
`else
   assign tx_cnt = '0;
   assign rx_cnt = '0;
`endif

   // Processor read mux; zero when not reading
   always_comb begin
      d_out = '0;
      if (rd) begin
         case (addr)
            ADDR_IN_BUF:   d_out = in_q;
            ADDR_IN_STAT:  d_out = DATA_W'({rx_cnt, 15'd0, in_full});
            ADDR_OUT_STAT: d_out = DATA_W'({tx_cnt, 15'd0, out_full});
            default:       d_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_gold_nic.sv
// Directed self-checking bench for gold_nic.
// Inputs change on the falling edge; outputs are checked shortly after,
// and state advances on the rising edge.
module tb_gold_nic;
   import gold_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        addr;
   logic [DATA_W-1:0] d_in;
   logic [DATA_W-1:0] d_out;
   logic              nic_en;
   logic              nic_wr_en;
   logic              net_so;
   logic              net_ro;
   logic [DATA_W-1:0] net_do;
   logic              net_polarity;
   logic              net_si;
   logic              net_ri;
   logic [DATA_W-1:0] net_di;

   int checks   = 0;
   int failures = 0;

   localparam logic [DATA_W-1:0] PKT_A  = 64'h0000_0000_4000_0040;
   localparam logic [DATA_W-1:0] PKT_B  = 64'h0000_0000_0000_DEAD;
   localparam logic [DATA_W-1:0] PKT_C  = 64'h8000_0000_0004_0001;
   localparam logic [DATA_W-1:0] PKT_RX = 64'h8000_0000_0000_1234;
   localparam logic [DATA_W-1:0] PKT_X  = 64'h0000_0000_5555_AAAA;

   always #5 clk = ~clk;

   gold_nic dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .nic_en       (nic_en),
      .nic_wr_en    (nic_wr_en),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di)
   );

   task automatic idle_inputs();
      nic_en = 1'b0; nic_wr_en = 1'b0; addr = 2'd0; d_in = '0;
      net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      #1;
      checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL reset_ri got=%b exp=1", net_ri); end
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL reset_so got=%b exp=0", net_so); end
      checks++; if (net_do !== 64'h0) begin failures++; $display("FAIL reset_do got=%h exp=0", net_do); end
      @(negedge clk);
      reset = 1'b1;
      nic_en = 1'b1; addr = ADDR_IN_STAT; #1;
      checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL reset_stat1 got=%h exp=0", d_out); end
      addr = ADDR_OUT_STAT; #1;
      checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL reset_stat3 got=%h exp=0", d_out); end
   endtask

   task automatic test_inject();
      @(negedge clk);
      idle_inputs();
      nic_en = 1'b1; nic_wr_en = 1'b1; addr = ADDR_OUT_BUF; d_in = PKT_A;
      net_ro = 1'b1; net_polarity = 1'b1;
      @(negedge clk);
      nic_en = 1'b0; nic_wr_en = 1'b0; #1;
      checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL idle_dout got=%h exp=0", d_out); end
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL inj_wrong_pol got=%b exp=0", net_so); end
      checks++; if (net_do !== PKT_A) begin failures++; $display("FAIL inj_do_held got=%h exp=%h", net_do, PKT_A); end
      nic_en = 1'b1; addr = ADDR_OUT_STAT; #1;
      checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL inj_outfull got=%h exp=1", d_out); end
      @(negedge clk);
      nic_en = 1'b0; net_polarity = 1'b0; #1;
      checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL inj_so got=%b exp=1", net_so); end
      checks++; if (net_do !== PKT_A) begin failures++; $display("FAIL inj_do got=%h exp=%h", net_do, PKT_A); end
      @(negedge clk);
      nic_en = 1'b1; addr = ADDR_OUT_STAT; #1;
      checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL inj_cleared got=%h exp=0", d_out); end
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL inj_so_after got=%b exp=0", net_so); end
      checks++; if (net_do !== 64'h0) begin failures++; $display("FAIL inj_do_after got=%h exp=0", net_do); end
   endtask

   task automatic test_drop();
      @(negedge clk);
      idle_inputs();
      nic_en = 1'b1; nic_wr_en = 1'b1; addr = ADDR_OUT_BUF; d_in = PKT_A;
      @(negedge clk);
      d_in = PKT_B;
      @(negedge clk);
      nic_wr_en = 1'b0; addr = ADDR_OUT_STAT; #1;
      checks++; if (net_do !== PKT_A) begin failures++; $display("FAIL drop_keep got=%h exp=%h", net_do, PKT_A); end
      checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL drop_full got=%h exp=1", d_out); end
      // write to a read-only address must not disturb anything
      nic_wr_en = 1'b1; addr = ADDR_IN_BUF; d_in = PKT_X;
      @(negedge clk);
      nic_en = 1'b0; nic_wr_en = 1'b0; net_ro = 1'b1; net_polarity = 1'b0; #1;
      checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL drop_drain got=%b exp=1", net_so); end
      @(negedge clk);
      nic_en = 1'b1; addr = ADDR_IN_BUF; #1;
      checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL ro_write got=%h exp=0", d_out); end
      checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL ro_write_ri got=%b exp=1", net_ri); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      idle_inputs();
      nic_en = 1'b1; nic_wr_en = 1'b1; addr = ADDR_OUT_BUF; d_in = PKT_A;
      @(negedge clk);
      // injection and a refill attempt in the same cycle: refill is dropped
      net_ro = 1'b1; net_polarity = 1'b0; d_in = PKT_C; #1;
      checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL b2b_so got=%b exp=1", net_so); end
      @(negedge clk);
      #1;
      checks++; if (net_do !== 64'h0) begin failures++; $display("FAIL b2b_drop got=%h exp=0", net_do); end
      @(negedge clk);
      nic_en = 1'b0; nic_wr_en = 1'b0; #1;
      checks++; if (net_do !== PKT_C) begin failures++; $display("FAIL b2b_refill got=%h exp=%h", net_do, PKT_C); end
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL b2b_odd_wait got=%b exp=0", net_so); end
      net_polarity = 1'b1; #1;
      checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL b2b_odd_so got=%b exp=1", net_so); end
      @(negedge clk);
      #1;
      checks++; if (net_do !== 64'h0) begin failures++; $display("FAIL b2b_empty got=%h exp=0", net_do); end
   endtask

   task automatic test_eject();
      @(negedge clk);
      idle_inputs();
      net_si = 1'b1; net_di = PKT_RX; #1;
      checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL ej_ri_pre got=%b exp=1", net_ri); end
      @(negedge clk);
      net_di = PKT_X; #1;
      checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL ej_ri_drop got=%b exp=0", net_ri); end
      nic_en = 1'b1; addr = ADDR_IN_STAT; #1;
      checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL ej_stat got=%h exp=1", d_out); end
      @(negedge clk);
      net_si = 1'b0; addr = ADDR_IN_BUF; #1;
      checks++; if (d_out !== PKT_RX) begin failures++; $display("FAIL ej_read got=%h exp=%h", d_out, PKT_RX); end
      @(negedge clk);
      nic_en = 1'b0; #1;
      checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL ej_ri_rise got=%b exp=1", net_ri); end
      nic_en = 1'b1; addr = ADDR_IN_BUF; #1;
      checks++; if (d_out !== PKT_RX) begin failures++; $display("FAIL ej_stale got=%h exp=%h", d_out, PKT_RX); end
      @(negedge clk);
      addr = ADDR_IN_STAT; #1;
      checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL ej_stat_clr got=%h exp=0", d_out); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      idle_inputs();
      nic_en = 1'b1; nic_wr_en = 1'b1; addr = ADDR_OUT_BUF; d_in = PKT_C;
      net_si = 1'b1; net_di = PKT_RX;
      @(negedge clk);
      idle_inputs();
      net_ro = 1'b1; net_polarity = 1'b1; #1;
      checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL mid_so_pre got=%b exp=1", net_so); end
      checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL mid_ri_pre got=%b exp=0", net_ri); end
      reset = 1'b0; #1;
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL mid_so got=%b exp=0", net_so); end
      checks++; if (net_do !== 64'h0) begin failures++; $display("FAIL mid_do got=%h exp=0", net_do); end
      checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL mid_ri got=%b exp=1", net_ri); end
      nic_en = 1'b1; addr = ADDR_IN_BUF; #1;
      checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL mid_inbuf got=%h exp=0", d_out); end
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
   endtask

`ifdef GOLD_NIC_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle_inputs();
         nic_en = 1'b1; nic_wr_en = 1'b1; addr = ADDR_OUT_BUF; d_in = PKT_A;
         @(negedge clk);
         idle_inputs();
         net_ro = 1'b1; net_polarity = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle_inputs();
         net_si = 1'b1; net_di = PKT_RX;
         @(negedge clk);
         idle_inputs();
         if (i == 0) begin
            nic_en = 1'b1; addr = ADDR_IN_BUF;
         end
      end
      @(negedge clk);
      idle_inputs();
      nic_en = 1'b1; addr = ADDR_OUT_STAT; #1;
      checks++; if (d_out !== 64'h0003_0000) begin failures++; $display("FAIL stats_tx got=%h exp=30000", d_out); end
      addr = ADDR_IN_STAT; #1;
      checks++; if (d_out !== 64'h0002_0001) begin failures++; $display("FAIL stats_rx got=%h exp=20001", d_out); end
   endtask
`endif

   initial begin
      test_reset();
      test_inject();
      test_drop();
      test_back_to_back();
      test_eject();
      test_reset_mid();
`ifdef GOLD_NIC_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
